// File: rtl/rsc_turbo_encoder.sv
// LTE 8-state rate-1/2 RSC constituent encoder (g0 = 1+D^2+D^3, g1 = 1+D+D^3).
// Emits bipolar sys/parity word pairs per information bit, then three trellis-termination pairs.
module rsc_turbo_encoder #(
  parameter int DWIDTH     = 16,
  parameter int BLKLEN_MAX = 6144,
  parameter int AMP        = 64
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [15:0]       blklen,
  input  logic              s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic              s_axis_in_tready,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tvalid,
  output logic [DWIDTH-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYS  = 3'd1,
    S_PAR  = 3'd2,
    S_TSYS = 3'd3,
    S_TPAR = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [15:0]       LEN_MAX = 16'(BLKLEN_MAX);
  localparam logic [DWIDTH-1:0] POS_W   = DWIDTH'(AMP);
  localparam logic [DWIDTH-1:0] NEG_W   = DWIDTH'(-AMP);

  // One trellis step: returns {x, z, next {s2,s1,s0}}; sr[0] is the newest delay element.
  function automatic logic [4:0] rsc_step(input logic u, input logic [2:0] sr);
    logic f;
    f = u ^ sr[1] ^ sr[2];
    return {u, f ^ sr[0] ^ sr[2], sr[1], sr[0], f};
  endfunction

  function automatic logic [DWIDTH-1:0] soft_word(input logic b);
    return b ? NEG_W : POS_W;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        sr_q, sr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        tcnt_q, tcnt_d;
  logic              pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              user_q, user_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;

  logic              slot_free_s;
  logic              in_rdy_s;
  logic              accept_s;
  logic [15:0]       len_eff_s;
  logic [4:0]        step_in_s;
  logic [4:0]        step_tail_s;

  assign slot_free_s = !valid_q || m_axis_out_tready;
  assign in_rdy_s    = aresetn && ((state_q == S_IDLE) || ((state_q == S_SYS) && slot_free_s));
  assign accept_s    = in_rdy_s && s_axis_in_tvalid;
  assign len_eff_s   = ((blklen == 16'd0) || (blklen > LEN_MAX)) ? LEN_MAX : blklen;
  assign step_in_s   = rsc_step(s_axis_in_tdata, sr_q);
  // Tail input cancels the feedback so the register flushes to zero in three steps.
  assign step_tail_s = rsc_step(sr_q[1] ^ sr_q[2], sr_q);

  // Next-state and output-slot logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tcnt_d  = tcnt_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    data_d  = data_q;
    user_d  = user_q;
    last_d  = last_q;
    busy_d  = busy_q;
    if (valid_q && m_axis_out_tready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    case (state_q)
      S_IDLE, S_SYS: begin
        if (accept_s) begin
          valid_d = 1'b1;
          data_d  = soft_word(step_in_s[4]);
          user_d  = (state_q == S_IDLE);
          last_d  = 1'b0;
          pend_d  = step_in_s[3];
          sr_d    = step_in_s[2:0];
          state_d = S_PAR;
          if (state_q == S_IDLE) begin
            len_d  = len_eff_s;
            cnt_d  = 16'd0;
            tcnt_d = 2'd0;
            busy_d = 1'b1;
          end else begin
            busy_d = busy_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_PAR: begin
        if (slot_free_s) begin
          valid_d = 1'b1;
          data_d  = soft_word(pend_q);
          user_d  = 1'b0;
          last_d  = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          state_d = ((cnt_q + 16'd1) == len_q) ? S_TSYS : S_SYS;
        end else begin
          state_d = S_PAR;
        end
      end
      S_TSYS: begin
        if (slot_free_s) begin
          valid_d = 1'b1;
          data_d  = soft_word(step_tail_s[4]);
          user_d  = 1'b0;
          last_d  = 1'b0;
          pend_d  = step_tail_s[3];
          sr_d    = step_tail_s[2:0];
          state_d = S_TPAR;
        end else begin
          state_d = S_TSYS;
        end
      end
      S_TPAR: begin
        if (slot_free_s) begin
          valid_d = 1'b1;
          data_d  = soft_word(pend_q);
          user_d  = 1'b0;
          last_d  = (tcnt_q == 2'd2);
          tcnt_d  = tcnt_q + 2'd1;
          state_d = (tcnt_q == 2'd2) ? S_DONE : S_TSYS;
        end else begin
          state_d = S_TPAR;
        end
      end
      S_DONE: begin
        if (valid_q && m_axis_out_tready) begin
          sr_d    = 3'd0;
          cnt_d   = 16'd0;
          tcnt_d  = 2'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      sr_q    <= 3'd0;
      cnt_q   <= 16'd0;
      len_q   <= 16'd0;
      tcnt_q  <= 2'd0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      user_q  <= user_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign s_axis_in_tready  = in_rdy_s;
  assign m_axis_out_tvalid = valid_q;
  assign m_axis_out_tdata  = data_q;
  assign m_axis_out_tuser  = user_q;
  assign m_axis_out_tlast  = last_q;
  assign o_busy            = busy_q;

endmodule
